// File: rtl/fetch_queue.sv
// Sequential RV32 instruction fetch front end: credit-limited requests to imem,
// in-order responses buffered in a FIFO toward decode, redirects flush and drop stale data.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dec_valid,
    output logic [DATA_W-1:0] dec_instr,
    output logic [31:0]       dec_pc,
    input  logic              dec_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [31:0]       pc_mem    [DEPTH];

    logic [CNT_W:0]    credit_used;
    logic              has_credit;
    logic              issue;
    logic              drop;
    logic              wr_en;
    logic              pop;
    logic [31:0]       redirect_target;

    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [CNT_W-1:0]  discard_nxt;

    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign has_credit  = credit_used < (CNT_W + 1)'(DEPTH);

    // Gated by rst_n so the request drops as soon as reset asserts.
    assign imem_req  = rst_n && !redirect_valid && has_credit;
    assign imem_addr = fetch_pc;

    assign issue     = imem_req && imem_gnt;
    assign drop      = imem_rvalid && (discard != '0);
    assign wr_en     = imem_rvalid && (discard == '0) && !redirect_valid;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready && !redirect_valid;

    assign dec_instr = dec_valid ? instr_mem[rd_ptr] : '0;
    assign dec_pc    = dec_valid ? pc_mem[rd_ptr] : RESET_PC;

    always_comb begin
        count_nxt       = count;
        outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);
        discard_nxt     = discard;

        if (redirect_valid) begin
            count_nxt   = '0;
            // Everything still in flight is stale; a response landing now is dropped too.
            discard_nxt = outstanding - CNT_W'(imem_rvalid);
        end else begin
            if (wr_en && !pop) begin
                count_nxt = count + CNT_W'(1);
            end else if (!wr_en && pop) begin
                count_nxt = count - CNT_W'(1);
            end
            if (drop) begin
                discard_nxt = discard - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            count       <= count_nxt;

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                rd_ptr   <= wr_ptr;
            end else begin
                if (issue) begin
                    fetch_pc <= pc_inc(fetch_pc);
                end
                if (wr_en) begin
                    resp_pc <= pc_inc(resp_pc);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage is data only; occupancy gates what decode can observe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && (count == CNT_W'(DEPTH))));

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (outstanding == '0)));

endmodule
